// File: rtl/bank_biu_rd_arb_if.sv
// AXI3 read-address and read-data channel bundle between the bank BIU arbiter and the memory side.
// The arbiter is the AXI master.
interface bank_biu_rd_arb_if #(
  parameter int unsigned ID_WIDTH   = 6,
  parameter int unsigned DATA_WIDTH = 256
);
  logic                  arvalid_o;
  logic                  arready_i;
  logic [ID_WIDTH+1:0]   arid_o;
  logic [31:0]           araddr_o;
  logic [2:0]            arsize_o;
  logic [3:0]            arlen_o;
  logic [1:0]            arburst_o;
  logic                  rvalid_i;
  logic [ID_WIDTH+1:0]   rid_i;
  logic [DATA_WIDTH-1:0] rdata_i;
  logic [1:0]            rresp_i;
  logic                  rlast_i;
  logic                  rready_o;

  modport master (
    output arvalid_o, arid_o, araddr_o, arsize_o, arlen_o, arburst_o, rready_o,
    input  arready_i, rvalid_i, rid_i, rdata_i, rresp_i, rlast_i
  );

  modport slave (
    input  arvalid_o, arid_o, araddr_o, arsize_o, arlen_o, arburst_o, rready_o,
    output arready_i, rvalid_i, rid_i, rdata_i, rresp_i, rlast_i
  );
endinterface

// File: rtl/bank_biu_rd_arb.sv
// Round-robin read arbiter: issues line-fill AR requests from 4 bank BIUs and routes R beats back.
// Optional sticky error capture is enabled by defining BANK_BIU_RD_ARB_RESP_ERR_EN.
module bank_biu_rd_arb #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned ID_WIDTH        = 6,
  parameter int unsigned DATA_WIDTH      = 256,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*27-1:0]         req_addr_i,
  input  logic [NUM_REQ*ID_WIDTH-1:0]   req_id_i,
  bank_biu_rd_arb_if.master             axi,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  input  logic [NUM_REQ-1:0]            rsp_ready_i,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic [ID_WIDTH-1:0]           rsp_id_o,
  output logic [3:0]                    outstanding_o
`ifdef BANK_BIU_RD_ARB_RESP_ERR_EN
  ,
  output logic                          err_o,
  output logic [ID_WIDTH+1:0]           err_id_o
`endif
);

  localparam int unsigned IDX_W = 2;

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e              r_state;
  logic                r_arvalid;
  logic [ID_WIDTH+1:0] r_arid;
  logic [31:0]         r_araddr;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [3:0]          r_outstanding;

  logic             w_found;
  logic [IDX_W-1:0] w_idx;
  logic             w_grant;
  logic             w_ar_hs;
  logic             w_r_hs;
  logic             w_inc;
  logic             w_dec;
  logic [IDX_W-1:0] w_rk;

  // Search for the first valid requester starting at the round-robin pointer.
  always_comb begin
    logic [IDX_W-1:0] cand;
    w_found = 1'b0;
    w_idx   = r_rr_ptr;
    cand    = r_rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = r_rr_ptr + IDX_W'(i);
      if (!w_found && req_valid_i[cand]) begin
        w_found = 1'b1;
        w_idx   = cand;
      end
    end
  end

  assign w_grant = (r_state == StIdle) && (r_outstanding < 4'(MAX_OUTSTANDING)) && w_found;

  always_comb begin
    req_ready_o = '0;
    if (w_grant && !rst_i) begin
      req_ready_o = NUM_REQ'(1) << w_idx;
    end
  end

  assign w_ar_hs = r_arvalid & axi.arready_i;
  assign w_r_hs  = axi.rvalid_i & axi.rready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= StIdle;
      r_arvalid <= 1'b0;
      r_arid    <= '0;
      r_araddr  <= '0;
      r_rr_ptr  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_grant) begin
            r_state   <= StIssue;
            r_arvalid <= 1'b1;
            r_arid    <= {w_idx, req_id_i[int'(w_idx)*ID_WIDTH +: ID_WIDTH]};
            r_araddr  <= {req_addr_i[int'(w_idx)*27 +: 27], 5'b0};
          end
        end
        StIssue: begin
          if (axi.arready_i) begin
            r_state   <= StIdle;
            r_arvalid <= 1'b0;
            r_rr_ptr  <= r_arid[ID_WIDTH +: IDX_W] + IDX_W'(1);
          end
        end
        default: begin
          r_state   <= StIdle;
          r_arvalid <= 1'b0;
        end
      endcase
    end
  end

  // Saturating in-flight count; a last beat with nothing outstanding is ignored.
  assign w_inc = w_ar_hs && (r_outstanding < 4'(MAX_OUTSTANDING));
  assign w_dec = w_r_hs && axi.rlast_i && (r_outstanding != 4'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_outstanding <= '0;
    end else if (w_inc && !w_dec) begin
      r_outstanding <= r_outstanding + 4'd1;
    end else if (w_dec && !w_inc) begin
      r_outstanding <= r_outstanding - 4'd1;
    end
  end

  assign outstanding_o  = r_outstanding;
  assign axi.arvalid_o  = r_arvalid;
  assign axi.arid_o     = r_arid;
  assign axi.araddr_o   = r_araddr;
  assign axi.arsize_o   = 3'b101;
  assign axi.arlen_o    = 4'b0000;
  assign axi.arburst_o  = 2'b01;

  assign w_rk = axi.rid_i[ID_WIDTH +: IDX_W];

  always_comb begin
    rsp_valid_o = '0;
    if (axi.rvalid_i) begin
      rsp_valid_o = NUM_REQ'(1) << w_rk;
    end
  end

  assign axi.rready_o = rsp_ready_i[w_rk];
  assign rsp_data_o   = axi.rdata_i;
  assign rsp_id_o     = axi.rid_i[ID_WIDTH-1:0];

`ifdef BANK_BIU_RD_ARB_RESP_ERR_EN
  logic                r_err;
  logic [ID_WIDTH+1:0] r_err_id;

  // Only the first failing response is recorded.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err    <= 1'b0;
      r_err_id <= '0;
    end else if (w_r_hs && (axi.rresp_i != 2'b00) && !r_err) begin
      r_err    <= 1'b1;
      r_err_id <= axi.rid_i;
    end
  end

  assign err_o    = r_err;
  assign err_id_o = r_err_id;
`else
  logic w_unused_rresp;
  assign w_unused_rresp = ^axi.rresp_i;
`endif

endmodule

// File: tb/tb_bank_biu_rd_arb.sv
// Directed self-checking bench for bank_biu_rd_arb: arbitration and routing tables plus
// hand-written stall, reset, round-robin and full-counter sequences.
module tb_bank_biu_rd_arb;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [107:0] req_addr;
  logic [23:0]  req_id;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready;
  logic [255:0] rsp_data;
  logic [5:0]   rsp_id;
  logic [3:0]   outstanding;
`ifdef BANK_BIU_RD_ARB_RESP_ERR_EN
  logic         err;
  logic [7:0]   err_id;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bank_biu_rd_arb_if #(.ID_WIDTH(6), .DATA_WIDTH(256)) axi_if ();

  bank_biu_rd_arb #(
    .NUM_REQ(4), .ID_WIDTH(6), .DATA_WIDTH(256), .MAX_OUTSTANDING(8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_id_i     (req_id),
    .axi          (axi_if),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .rsp_id_o     (rsp_id),
    .outstanding_o(outstanding)
`ifdef BANK_BIU_RD_ARB_RESP_ERR_EN
    ,
    .err_o        (err),
    .err_id_o     (err_id)
`endif
  );

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_ready;
    logic [1:0] exp_idx;
  } arb_vec_t;

  typedef struct {
    logic       rvalid;
    logic [7:0] rid;
    logic [3:0] ready;
    logic [1:0] rresp;
    logic [3:0] exp_valid;
    logic       exp_rready;
    logic [5:0] exp_id;
  } rt_vec_t;

  arb_vec_t arb_tbl[6];
  rt_vec_t  rt_tbl[6];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tags();
    for (int k = 0; k < 4; k++) begin
      req_addr[k*27 +: 27] = 27'h100 + 27'(k);
      req_id[k*6 +: 6]     = 6'h10 + 6'(k);
    end
  endtask

  task automatic do_reset();
    req_valid = 4'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] g_idx;
    int         n_grants;
    logic [1:0] rr_exp[5];

    arb_tbl[0] = '{4'b0010, 4'b0010, 2'd1};
    arb_tbl[1] = '{4'b0011, 4'b0001, 2'd0};
    arb_tbl[2] = '{4'b1001, 4'b1000, 2'd3};
    arb_tbl[3] = '{4'b1111, 4'b0001, 2'd0};
    arb_tbl[4] = '{4'b0101, 4'b0100, 2'd2};
    arb_tbl[5] = '{4'b0110, 4'b0010, 2'd1};

    rt_tbl[0] = '{1'b1, 8'hC3, 4'b1000, 2'b10, 4'b1000, 1'b1, 6'h03};
    rt_tbl[1] = '{1'b1, 8'h05, 4'b0001, 2'b00, 4'b0001, 1'b1, 6'h05};
    rt_tbl[2] = '{1'b1, 8'h9F, 4'b1011, 2'b00, 4'b0100, 1'b0, 6'h1F};
    rt_tbl[3] = '{1'b0, 8'h7A, 4'b0010, 2'b00, 4'b0000, 1'b1, 6'h3A};
    rt_tbl[4] = '{1'b1, 8'h41, 4'b1101, 2'b11, 4'b0010, 1'b0, 6'h01};
    rt_tbl[5] = '{1'b1, 8'hE2, 4'b1000, 2'b01, 4'b1000, 1'b1, 6'h22};

    rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd2; rr_exp[3] = 2'd3; rr_exp[4] = 2'd0;

    rst = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 4'h0;
    set_tags();
    axi_if.arready_i = 1'b0;
    axi_if.rvalid_i  = 1'b0;
    axi_if.rid_i     = '0;
    axi_if.rdata_i   = '0;
    axi_if.rresp_i   = 2'b00;
    axi_if.rlast_i   = 1'b0;

    // Reset state, with every requester asking.
    #3;
    check("rst_req_ready", 256'(req_ready), 256'(4'b0));
    check("rst_arvalid", 256'(axi_if.arvalid_o), 256'(1'b0));
    check("rst_outstanding", 256'(outstanding), 256'(4'd0));
    check("rst_arid", 256'(axi_if.arid_o), 256'(8'h00));
    check("rst_araddr", 256'(axi_if.araddr_o), 256'(32'h0));
    req_valid = 4'b0;
    tick();
    rst = 1'b0;

    // Arbitration table: one grant per row, arready always high.
    axi_if.arready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_valid = arb_tbl[i].valid;
      @(negedge clk);
      check($sformatf("arb%0d_ready", i), 256'(req_ready), 256'(arb_tbl[i].exp_ready));
      check($sformatf("arb%0d_cnt", i), 256'(outstanding), 256'(i));
      tick();
      req_valid = 4'b0;
      @(negedge clk);
      check($sformatf("arb%0d_arvalid", i), 256'(axi_if.arvalid_o), 256'(1'b1));
      check($sformatf("arb%0d_arid", i), 256'(axi_if.arid_o),
            256'({arb_tbl[i].exp_idx, 6'h10 + 6'(arb_tbl[i].exp_idx)}));
      check($sformatf("arb%0d_araddr", i), 256'(axi_if.araddr_o),
            256'({27'h100 + 27'(arb_tbl[i].exp_idx), 5'b0}));
      tick();
    end
    @(negedge clk);
    check("arb_cnt_final", 256'(outstanding), 256'(4'd6));

    // Drain six plus one extra beat that must not wrap the counter.
    tick();
    axi_if.rvalid_i = 1'b1;
    axi_if.rlast_i  = 1'b1;
    axi_if.rid_i    = 8'h00;
    rsp_ready       = 4'hF;
    repeat (7) tick();
    axi_if.rvalid_i = 1'b0;
    @(negedge clk);
    check("drain_cnt_zero", 256'(outstanding), 256'(4'd0));

    // Single request: requester 1, addr 1, tag 5.
    tick();
    req_id[6 +: 6]    = 6'h05;
    req_addr[27 +: 27] = 27'h1;
    req_valid = 4'b0010;
    @(negedge clk);
    check("single_ready", 256'(req_ready), 256'(4'b0010));
    tick();
    req_valid = 4'b0;
    @(negedge clk);
    check("single_arvalid", 256'(axi_if.arvalid_o), 256'(1'b1));
    check("single_arid", 256'(axi_if.arid_o), 256'(8'h45));
    check("single_araddr", 256'(axi_if.araddr_o), 256'(32'h20));
    check("single_cnt0", 256'(outstanding), 256'(4'd0));
    tick();
    @(negedge clk);
    check("single_cnt1", 256'(outstanding), 256'(4'd1));
    check("single_ar_drop", 256'(axi_if.arvalid_o), 256'(1'b0));
    set_tags();

    // Round robin with all requesters valid continuously.
    tick();
    do_reset();
    req_valid = 4'hF;
    n_grants = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_ready != 4'b0) begin
        g_idx = 2'd0;
        for (int k = 0; k < 4; k++) if (req_ready[k]) g_idx = 2'(k);
        if (n_grants < 5) begin
          check($sformatf("rr_order%0d", n_grants), 256'(g_idx), 256'(rr_exp[n_grants]));
          check($sformatf("rr_cycle%0d", n_grants), 256'(c), 256'(2 * n_grants));
        end
        n_grants++;
      end
      tick();
    end
    req_valid = 4'b0;
    check("rr_num_grants", 256'(n_grants), 256'(5));

    // AR stall: arready low for five cycles with a requester still asking.
    do_reset();
    axi_if.arready_i = 1'b0;
    req_valid = 4'b0100;
    @(negedge clk);
    check("stall_grant", 256'(req_ready), 256'(4'b0100));
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d_arvalid", c), 256'(axi_if.arvalid_o), 256'(1'b1));
      check($sformatf("stall%0d_arid", c), 256'(axi_if.arid_o), 256'(8'h92));
      check($sformatf("stall%0d_araddr", c), 256'(axi_if.araddr_o), 256'({27'h102, 5'b0}));
      check($sformatf("stall%0d_ready", c), 256'(req_ready), 256'(4'b0));
      tick();
    end
    axi_if.arready_i = 1'b1;
    tick();
    axi_if.arready_i = 1'b0;
    @(negedge clk);
    check("stall_cnt", 256'(outstanding), 256'(4'd1));
    check("stall_regrant", 256'(req_ready), 256'(4'b0100));
    tick();
    @(negedge clk);
    check("midissue_arvalid_pre", 256'(axi_if.arvalid_o), 256'(1'b1));
    #2;
    rst = 1'b1;
    #1;
    check("midissue_arvalid", 256'(axi_if.arvalid_o), 256'(1'b0));
    check("midissue_cnt", 256'(outstanding), 256'(4'd0));
    check("midissue_ready", 256'(req_ready), 256'(4'b0));
    check("midissue_arid", 256'(axi_if.arid_o), 256'(8'h00));
    tick();
    req_valid = 4'b0;
    rst = 1'b0;

    // Fill to the outstanding limit, then release one slot.
    do_reset();
    axi_if.arready_i = 1'b1;
    req_valid = 4'hF;
    repeat (16) tick();
    @(negedge clk);
    check("full_cnt", 256'(outstanding), 256'(4'd8));
    check("full_ready", 256'(req_ready), 256'(4'b0));
    tick();
    @(negedge clk);
    check("full_ready_hold", 256'(req_ready), 256'(4'b0));
    tick();
    axi_if.rvalid_i = 1'b1;
    axi_if.rlast_i  = 1'b1;
    axi_if.rid_i    = 8'h40;
    rsp_ready       = 4'hF;
    @(negedge clk);
    check("full_rready", 256'(axi_if.rready_o), 256'(1'b1));
    tick();
    axi_if.rvalid_i = 1'b0;
    @(negedge clk);
    check("full_cnt_dec", 256'(outstanding), 256'(4'd7));
    check("full_regrant", 256'(req_ready), 256'(4'b0001));
    tick();
    req_valid = 4'b0;
    tick();
    @(negedge clk);
    check("full_cnt_back", 256'(outstanding), 256'(4'd8));

    // Response routing table.
    tick();
    do_reset();
    axi_if.rlast_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      axi_if.rvalid_i = rt_tbl[i].rvalid;
      axi_if.rid_i    = rt_tbl[i].rid;
      axi_if.rresp_i  = rt_tbl[i].rresp;
      axi_if.rdata_i  = {8{32'hA5A5_0000 + 32'(i)}};
      rsp_ready       = rt_tbl[i].ready;
      @(negedge clk);
      check($sformatf("rt%0d_valid", i), 256'(rsp_valid), 256'(rt_tbl[i].exp_valid));
      check($sformatf("rt%0d_rready", i), 256'(axi_if.rready_o), 256'(rt_tbl[i].exp_rready));
      check($sformatf("rt%0d_id", i), 256'(rsp_id), 256'(rt_tbl[i].exp_id));
      check($sformatf("rt%0d_data", i), rsp_data, {8{32'hA5A5_0000 + 32'(i)}});
      tick();
    end
    axi_if.rvalid_i = 1'b0;
    @(negedge clk);
    check("rt_cnt", 256'(outstanding), 256'(4'd0));
`ifdef BANK_BIU_RD_ARB_RESP_ERR_EN
    check("err_set", 256'(err), 256'(1'b1));
    check("err_id", 256'(err_id), 256'(8'hC3));
    tick();
    do_reset();
    @(negedge clk);
    check("err_clear", 256'(err), 256'(1'b0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
